pla_eval_scheduler: RTL and testbench



---
 rtl/pla_sched_pkg.sv | 15 +
 rtl/pla_eval_scheduler_rr_arbiter.sv | 39 +++
 rtl/pla_eval_scheduler.sv | 115 +++++++++++
 tb/tb_pla_eval_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pla_sched_pkg.sv
// Shared types and helpers for the PLA evaluation scheduler.
// Fixed PLA geometry plus the round-robin pointer advance.
package pla_sched_pkg;

  localparam int PLA_IN_W  = 9;
  localparam int PLA_OUT_W = 14;

  typedef logic [PLA_IN_W-1:0]  pla_in_t;
  typedef logic [PLA_OUT_W-1:0] pla_out_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pla_eval_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, with wrap.
// Grant vector and index are purely combinational.
module rr_arbiter
  import pla_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic          found;
  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (en && !found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/pla_eval_scheduler.sv
// Time-shares one combinational PLA between NUM_REQ requesters.
// Stage A registers the granted vector, stage B captures the PLA result.
module pla_eval_scheduler
  import pla_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = PLA_IN_W,
  parameter int OUT_W   = PLA_OUT_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         pla_x,
  input  logic [OUT_W-1:0]        pla_z,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  logic              a_valid_q, a_valid_d;
  logic [ID_W-1:0]   a_id_q, a_id_d;
  logic [IN_W-1:0]   x_q, x_d;
  logic              b_valid_q, b_valid_d;
  logic [OUT_W-1:0]  z_q, z_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              adv_a, adv_b;
  logic              arb_en, hs;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [IN_W-1:0]   sel_data;

  assign adv_b  = !b_valid_q || rsp_ready;
  assign adv_a  = !a_valid_q || adv_b;
  // No grants while reset is held low.
  assign arb_en = adv_a && rst_n;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_data = req_data[i*IN_W +: IN_W];
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_id_d    = a_id_q;
    x_d       = x_q;
    ptr_d     = ptr_q;
    b_valid_d = b_valid_q;
    z_d       = z_q;
    id_d      = id_q;
    if (adv_a) begin
      a_valid_d = hs;
      if (hs) begin
        x_d    = sel_data;
        a_id_d = gnt_idx;
        ptr_d  = ID_W'(rr_next(int'(gnt_idx), NUM_REQ));
      end
    end
    if (adv_b) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        z_d  = pla_z;
        id_d = a_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_id_q    <= '0;
      x_q       <= '0;
      ptr_q     <= '0;
      b_valid_q <= 1'b0;
      z_q       <= '0;
      id_q      <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_id_q    <= a_id_d;
      x_q       <= x_d;
      ptr_q     <= ptr_d;
      b_valid_q <= b_valid_d;
      z_q       <= z_d;
      id_q      <= id_d;
    end
  end

  assign pla_x     = x_q;
  assign rsp_valid = b_valid_q;
  assign rsp_data  = z_q;
  assign rsp_id    = id_q;
  assign busy      = a_valid_q | b_valid_q;

endmodule

// File: tb/tb_pla_eval_scheduler.sv
// Scoreboard bench for pla_eval_scheduler with a stand-in PLA.
// Requester sources are queues; accepts push expectations, responses pop.
module tb_pla_eval_scheduler;
  import pla_sched_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 9;
  localparam int OW  = 14;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*IW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [IW-1:0]   pla_x;
  logic [OW-1:0]   pla_z;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [OW-1:0]   rsp_data;
  logic [IDW-1:0]  rsp_id;
  logic            busy;

  always #5 clk = ~clk;

  pla_eval_scheduler #(
    .NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .pla_x(pla_x), .pla_z(pla_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy)
  );

  // Stand-in decoder; x = 9'h001 yields 14'h00C9 (z0, z3, z6, z7).
  function automatic pla_out_t pla_f(input pla_in_t x);
    return ({5'b0, x} * 14'd201) ^ {x[8:4], 9'b0};
  endfunction

  assign pla_z = pla_f(pla_x);

  typedef struct {
    logic [IDW-1:0] id;
    pla_out_t       z;
  } exp_t;

  exp_t    sb[$];
  pla_in_t src[N][$];
  int      acc_ids[$];
  int      n_rsp = 0;
  int      checks = 0;
  int      errors = 0;
  exp_t    e_new, e_got;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver: present the head of each source queue.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*IW +: IW] = src[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*IW +: IW] = '0;
      end
    end
  end

  // Monitor: both handshakes complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {18'b0, rsp_data}, 32'hFFFF_FFFF);
        end else begin
          e_got = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e_got.id));
          chk("rsp_data", 32'(rsp_data), 32'(e_got.z));
          n_rsp++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i] && src[i].size() > 0) begin
          e_new.id = IDW'(i);
          e_new.z  = pla_f(src[i][0]);
          sb.push_back(e_new);
          acc_ids.push_back(i);
          void'(src[i].pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      if (src_empty() && sb.size() == 0 && !busy && !rsp_valid) break;
      step();
    end
    chk(tag, 32'(k < 300), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, first_c, last_c, cyc, pos, nr;
    logic exp_v, exp_b;
    pla_in_t d1, d2;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset state, with a request pending
    src[0].push_back(9'h1FF);
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pla_x", 32'(pla_x), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    src[0].delete();
    step();
    rst_n = 1'b1;

    // Single request, basic path
    src[2].push_back(9'h001);
    step();
    chk("t1_ready", 32'(req_ready), 32'b0100);
    step();
    chk("t1_pla_x", 32'(pla_x), 32'h001);
    chk("t1_rsp_v0", 32'(rsp_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    chk("t1_rsp_v1", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", 32'(rsp_data), 32'h00C9);
    chk("t1_rsp_id", 32'(rsp_id), 32'd2);
    step();
    chk("t1_rsp_v2", 32'(rsp_valid), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Simultaneous requests from pointer 0
    do_reset();
    base = acc_ids.size();
    nr = n_rsp;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++)
        src[i].push_back(9'(i * 37 + k * 101 + 3));
    first_c = -1;
    last_c = -1;
    for (cyc = 0; cyc < 100; cyc++) begin
      step();
      if (rsp_valid) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      if (n_rsp == nr + 12 && sb.size() == 0) break;
    end
    chk("t2_done", 32'(n_rsp - nr), 32'd12);
    chk("t2_b2b_span", 32'(last_c - first_c), 32'd11);
    for (int k = 0; k < 12; k++)
      if (base + k < acc_ids.size())
        chk($sformatf("t2_order%0d", k), 32'(acc_ids[base + k]),
            32'(k % N));
    drain("t2_drain");

    // Backpressure
    rsp_ready = 1'b0;
    base = acc_ids.size();
    nr = n_rsp;
    for (int k = 0; k < 6; k++) src[0].push_back(9'(9'h100 + k));
    for (int s = 1; s <= 5; s++) begin
      step();
      if (s >= 3) begin
        chk("t3_ready0", 32'(req_ready), 32'd0);
        chk("t3_rsp_v", 32'(rsp_valid), 32'd1);
        chk("t3_pla_x", 32'(pla_x), 32'h101);
        chk("t3_rsp_data", 32'(rsp_data), 32'(pla_f(9'h100)));
        chk("t3_rsp_id", 32'(rsp_id), 32'd0);
      end
    end
    chk("t3_accepts", 32'(acc_ids.size() - base), 32'd2);
    rsp_ready = 1'b1;
    drain("t3_drain");
    chk("t3_rsp_count", 32'(n_rsp - nr), 32'd6);

    // Reset mid-operation (pointer is 1 here)
    rsp_ready = 1'b0;
    src[0].push_back(9'h0A0);
    src[0].push_back(9'h0A1);
    src[2].push_back(9'h0B0);
    src[2].push_back(9'h0B1);
    step();
    chk("t4_first_gnt", 32'(req_ready), 32'b0100);
    step();
    step();
    chk("t4_full_busy", 32'(busy), 32'd1);
    chk("t4_full_rsp_v", 32'(rsp_valid), 32'd1);
    chk("t4_full_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    step();
    chk("t4_rst_rsp_v", 32'(rsp_valid), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_pla_x", 32'(pla_x), 32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    base = acc_ids.size();
    drain("t4_drain");
    chk("t4_acc_count", 32'(acc_ids.size() - base), 32'd2);
    if (acc_ids.size() >= base + 2) begin
      chk("t4_acc0", 32'(acc_ids[base]), 32'd0);
      chk("t4_acc1", 32'(acc_ids[base + 1]), 32'd2);
    end

    // Wrap: pointer at 3, only 3 and 0 valid
    base = acc_ids.size();
    for (int k = 0; k < 2; k++) begin
      src[3].push_back(9'(9'h030 + k));
      src[0].push_back(9'(9'h0C0 + k));
    end
    drain("t5_drain");
    chk("t5_acc_count", 32'(acc_ids.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      if (base + k < acc_ids.size())
        chk($sformatf("t5_order%0d", k), 32'(acc_ids[base + k]),
            (k % 2 == 0) ? 32'd3 : 32'd0);

    // Fairness: requester 1 joins a running 3/0 stream
    for (int k = 0; k < 5; k++) begin
      src[3].push_back(9'(9'h1E0 + k));
      src[0].push_back(9'(9'h070 + k));
    end
    step();
    step();
    base = acc_ids.size();
    src[1].push_back(9'h111);
    drain("t5_fair_drain");
    pos = -1;
    for (int k = base; k < acc_ids.size(); k++)
      if (pos < 0 && acc_ids[k] == 1) pos = k - base;
    chk("t5_fair_found", 32'(pos >= 0), 32'd1);
    chk("t5_fair_within", 32'(pos < N), 32'd1);

    // Idle gap between two requests
    d1 = 9'h155;
    d2 = 9'h0AA;
    nr = n_rsp;
    src[1].push_back(d1);
    for (int s = 1; s <= 10; s++) begin
      step();
      exp_v = (s == 3) || (s == 8);
      exp_b = (s == 2) || (s == 3) || (s == 7) || (s == 8);
      chk($sformatf("t6_rsp_v_c%0d", s), 32'(rsp_valid), 32'(exp_v));
      chk($sformatf("t6_busy_c%0d", s), 32'(busy), 32'(exp_b));
      if (s >= 2)
        chk($sformatf("t6_pla_x_c%0d", s), 32'(pla_x),
            (s >= 7) ? 32'(d2) : 32'(d1));
      if (s == 5) src[1].push_back(d2);
    end
    chk("t6_rsp_count", 32'(n_rsp - nr), 32'd2);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
